// File: rtl/wb_burst_ram.sv
// Wishbone B3 single-port 32-bit RAM slave with classic and incrementing-burst (linear/wrap4/8/16) support.
// Define WB_BURST_RAM_ERR_EN to answer out-of-range word addresses with err_o; otherwise addresses alias.
module wb_burst_ram #(
    parameter int    MEM_WORDS = 1024,
    parameter string MEMFILE   = ""
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t        state, state_n;
    logic          ack_q, ack_n;
    logic          err_q, err_n;
    logic [31:0]   dat_q;
    logic [AW-1:0] cur_adr, cur_n;
    logic [AW-1:0] nxt;
    logic [AW-1:0] adr_word;
    logic [AW-1:0] rd_adr;
    logic          rd_en;
    logic          accept;
    logic          wr_en;
    logic          first_bad;
    logic          nxt_bad;
    logic          unused_bits;

    logic [31:0]   mem [MEM_WORDS];

    assign adr_word = wb_adr_i[AW+1:2];
    assign accept   = wb_cyc_i & wb_stb_i & ack_q;
    assign wr_en    = accept & wb_we_i & wb_rst_n_i & ~first_bad;

`ifdef WB_BURST_RAM_ERR_EN
    // Only a linear burst can step past the top word; wrapping bursts stay inside their block.
    assign first_bad   = |wb_adr_i[31:AW+2];
    assign nxt_bad     = (wb_bte_i == 2'b00) && (cur_adr == {AW{1'b1}});
    assign unused_bits = ^{wb_adr_i[1:0], MEMFILE != ""};
`else
    assign first_bad   = 1'b0;
    assign nxt_bad     = 1'b0;
    assign unused_bits = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0], MEMFILE != ""};
`endif

    always_comb begin
        case (wb_bte_i)
            2'b01:   nxt = {cur_adr[AW-1:2], cur_adr[1:0] + 2'd1};
            2'b10:   nxt = {cur_adr[AW-1:3], cur_adr[2:0] + 3'd1};
            2'b11:   nxt = {cur_adr[AW-1:4], cur_adr[3:0] + 4'd1};
            default: nxt = cur_adr + AW'(1);
        endcase
    end

    always_comb begin
        state_n = state;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        cur_n   = cur_adr;
        rd_en   = 1'b0;
        rd_adr  = cur_adr;
        case (state)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i && !ack_q && !err_q) begin
                    if (first_bad) begin
                        err_n = 1'b1;
                    end else begin
                        ack_n  = 1'b1;
                        rd_en  = 1'b1;
                        rd_adr = adr_word;
                        cur_n  = adr_word;
                        if (wb_cti_i == 3'b010) state_n = BURST;
                    end
                end
            end
            BURST: begin
                if (!wb_cyc_i) begin
                    state_n = IDLE;
                end else if (wb_stb_i) begin
                    if (ack_q) begin
                        // Beat accepted: prefetch the following word so acks stay back-to-back.
                        if (wb_cti_i == 3'b010) begin
                            if (nxt_bad) begin
                                err_n   = 1'b1;
                                state_n = IDLE;
                            end else begin
                                ack_n  = 1'b1;
                                cur_n  = nxt;
                                rd_en  = 1'b1;
                                rd_adr = nxt;
                            end
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        // Strobe returned after a wait state: replay the held address.
                        ack_n = 1'b1;
                        rd_en = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state   <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= 32'h0;
            cur_adr <= '0;
        end else begin
            state   <= state_n;
            ack_q   <= ack_n;
            err_q   <= err_n;
            cur_adr <= cur_n;
            if (rd_en) dat_q <= mem[rd_adr];
        end
    end

    // Memory has no reset so its contents survive a bus reset.
    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_sel_i[i]) mem[adr_word][8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign wb_rty_o = 1'b0;

endmodule
